// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 responder. SCL, CS and MOSI are oversampled on clk; words are
// exchanged with local logic via a one-entry TX holding register and an RX
// output register that pulses rx_valid on each completed word.
//
// state | meaning
// IDLE  | not selected; miso released (oe=0, miso=1)
// SHIFT | selected; shifting words on detected scl edges
module spi_slave_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = 8'hFF,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  SPI_reset,
  input  logic                  spi_scl,
  input  logic                  spi_cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  scl_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    scl_hist;
  logic                    cs_hist;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_full;

  logic                    scl_s;
  logic                    cs_s;
  logic                    mosi_s;
  logic                    scl_rise;
  logic                    scl_fall;
  logic                    cs_rise;
  logic                    cs_fall;
  logic                    load_now;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [DATA_WIDTH-1:0]   rx_next;

  // Pin synchronizers plus history flops; preset to the idle bus levels.
  always_ff @(posedge clk) begin
    if (SPI_reset) begin
      scl_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      scl_hist  <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], spi_scl};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      scl_hist  <= scl_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist;
  assign scl_fall = ~scl_s & scl_hist;
  assign cs_rise  = cs_s & ~cs_hist;
  assign cs_fall  = ~cs_s & cs_hist;

  assign tx_ready = ~hold_full;

  // Load points: start of selection, and the scl fall that follows a completed word.
  always_comb begin
    load_word = hold_full ? hold_data : DEFAULT_TX;
    load_now  = ((state == IDLE) && cs_fall) ||
                ((state == SHIFT) && !cs_rise && scl_fall && (bit_cnt == '0));
    accept    = tx_valid && !hold_full;
    rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  end

  // Transfer FSM with registered outputs, shift registers and TX holding register.
  always_ff @(posedge clk) begin
    if (SPI_reset) begin
      state       <= IDLE;
      miso        <= 1'b1;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (load_now) begin
        tx_shift    <= load_word;
        miso        <= load_word[DATA_WIDTH-1];
        tx_underrun <= ~hold_full;
      end

      // Accept uses the start-of-cycle empty flag, so a load never bypasses to tx_data.
      if (load_now && hold_full) hold_full <= 1'b0;
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            miso_oe <= 1'b1;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
            miso    <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end else if (scl_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (scl_fall && (bit_cnt != '0)) begin
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[DATA_WIDTH-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
